// File: rtl/pair_frame_reader.sv
// rtl/pair_frame_reader.sv - paired even/odd frame RAM reader serializing word pairs into one pixel stream
// Optional build macro PAIR_FRAME_READER_CKSUM_EN adds a 16-bit running sum of accepted pixels (cksum).
module pair_frame_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int START_PAIR = 7296,
  parameter int END_PAIR   = 7424
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] rdata_a,
  input  logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef PAIR_FRAME_READER_CKSUM_EN
  ,
  output logic [15:0]       cksum
`endif
);

  localparam int P_W = ADDR_W - 1;
  localparam logic [P_W-1:0]    P_START = P_W'(START_PAIR);
  localparam logic [ADDR_W-1:0] P_END   = ADDR_W'(END_PAIR);
  localparam bit                EMPTY   = (START_PAIR >= END_PAIR);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    SEND_A  = 3'd3,
    SEND_B  = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [P_W-1:0]    p, p_nxt;
  logic [DATA_W-1:0] ha, hb;
  logic              last_pair;

  // Compare at full address width so p+1 cannot wrap before the bound test.
  assign last_pair = (({1'b0, p} + ADDR_W'(1)) >= P_END);

  assign addr_a = {p, 1'b0};
  assign addr_b = {p, 1'b1};

  // State, pair index and hold registers; hold data only latched in CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      p     <= P_START;
      ha    <= '0;
      hb    <= '0;
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      if (state == CAPTURE) begin
        ha <= rdata_a;
        hb <= rdata_b;
      end
    end
  end

  // Next-state, index advance and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (!EMPTY) begin
            p_nxt     = P_START;
            state_nxt = ISSUE;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      ISSUE: begin
        rd_en     = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = SEND_A;
      SEND_A: begin
        out_valid = 1'b1;
        out_data  = ha;
        if (out_ready) state_nxt = SEND_B;
      end
      SEND_B: begin
        out_valid = 1'b1;
        out_data  = hb;
        if (out_ready) begin
          if (!last_pair) begin
            p_nxt     = p + P_W'(1);
            state_nxt = ISSUE;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PAIR_FRAME_READER_CKSUM_EN
  // Running mod-2^16 sum of accepted pixels; cleared when a pass is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum <= '0;
    end else if (state == IDLE && start) begin
      cksum <= '0;
    end else if (out_valid && out_ready) begin
      cksum <= cksum + 16'(out_data);
    end
  end
`endif

endmodule

// File: doc/pair_frame_reader.md
# pair_frame_reader

Read-side counterpart of the draw block's paired address counter. On a start pulse, it walks a pair-index range and issues even/odd word reads to a dual-port frame RAM with 1-cycle read latency. It then serializes each returned pair into a single valid/ready pixel stream, even word first. It sits between the frame RAM read ports and the display/readback path.

## Interface
- ADDR_W, 14, full word-address width; the pair index is ADDR_W-1 bits.
- DATA_W, 8, width of one RAM word / output pixel.
- START_PAIR, 7296, first pair index read (inclusive).
- END_PAIR, 7424, pair index bound (exclusive).
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of a pass.
- rd_en  output  1  read strobe to both RAM ports.
- addr_a  output  ADDR_W  even word address {p, 1'b0}.
- addr_b  output  ADDR_W  odd word address {p, 1'b1}.
- rdata_a  input  DATA_W  port-A read data, valid the cycle after rd_en.
- rdata_b  input  DATA_W  port-B read data, valid the cycle after rd_en.
- out_data  output  DATA_W  serialized pixel.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the pixel when out_valid && out_ready.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, SEND_A, SEND_B, FIN.
- IDLE:
  - If start=1 and START_PAIR < END_PAIR: load p=START_PAIR and go to ISSUE.
  - If start=1 and START_PAIR >= END_PAIR: go to FIN with no reads issued.
- ISSUE: rd_en=1; addr_a/addr_b are driven from p. Next state is CAPTURE.
- CAPTURE: latch rdata_a and rdata_b into hold registers ha/hb. Next state is SEND_A.
- SEND_A: out_valid=1, out_data=ha. On handshake, go to SEND_B.
- SEND_B: out_valid=1, out_data=hb. On handshake:
  - If p+1 < END_PAIR: p <= p+1 and go to ISSUE.
  - Otherwise go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- rd_en, out_valid and done are decoded from state only.
- addr_a/addr_b are driven from p in all states; they are only meaningful when rd_en=1.
- Arithmetic:
  - p is ADDR_W-1 bits, unsigned; the comparison p+1 < END_PAIR is done at ADDR_W bits so there is no wrap.
  - p never exceeds END_PAIR-1.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0. ha/hb are not overwritten until the SEND_B handshake.
- Output order is strictly pixel 2p, then 2p+1, with p ascending.

## Timing
- Reset values: state=IDLE, p=START_PAIR, ha=hb=0, busy=0, done=0, rd_en=0, out_valid=0, out_data=0, addr_a={START_PAIR,0}, addr_b={START_PAIR,1}.
- Reset asserted mid-pass:
  - Next edge returns to IDLE.
  - Pending data is dropped with no done pulse.
  - Any RAM data in flight is ignored.
- Start sampled at edge t gives ISSUE in cycle t+1, CAPTURE in t+2, first out_valid in t+3.
- With out_ready held at 1: 4 cycles per pair and 2 pixels per 4 cycles.
- done is asserted in the cycle after the final SEND_B handshake.
- busy falls the cycle after done.
- Backpressure adds exactly one cycle per stalled cycle; no pixel is lost or duplicated.

## Configuration
- Macro: PAIR_FRAME_READER_CKSUM_EN.
- Defined:
  - Adds output port cksum [15:0].
  - cksum is the mod-2^16 running sum of every accepted out_data.
  - It clears to 0 on reset and on start accepted in IDLE, and holds after FIN.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Default params, RAM word[n]=n[7:0], out_ready=1, start pulse → 256 pixels 0x00..0xFF in order. First valid arrives 3 cycles after start. done pulses once, 513 cycles after start; busy=0 afterwards.
- Random out_ready (50%) → same 256-value sequence. out_data stays stable while stalled. rd_en pulses exactly 128 times, with addr_a 14592..14846 step 2 and addr_b = addr_a+1.
- START_PAIR=END_PAIR=5, start → no rd_en, no out_valid; done pulses 1 cycle after start.
- Reset asserted during SEND_B of pair 7300 → next cycle out_valid=0, busy=0, no done pulse. A fresh start re-reads from pair 7296.
- start re-pulsed while busy → ignored; pixel count stays 256 and a single done pulse is produced.
- With PAIR_FRAME_READER_CKSUM_EN and RAM word[n]=n[7:0] → cksum=0x7F80 after done; cksum=0 after a new start.
